// File: rtl/axi_sram_pkg.sv
// Shared types and widths for the AXI4 SRAM responder.
//   burst_t    : AXI burst encodings (FIXED/INCR/WRAP)
//   resp_t     : AXI response codes used here (OKAY/SLVERR)
//   wr_state_t : write channel FSM states
//   rd_state_t : read channel FSM states
package axi_sram_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;
    localparam int AXI_LEN_W  = 8;
    localparam int AXI_SIZE_W = 3;

    typedef enum logic [1:0] {
        BurstFixed = 2'b00,
        BurstIncr  = 2'b01,
        BurstWrap  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        RespOkay   = 2'b00,
        RespSlverr = 2'b10
    } resp_t;

    typedef enum logic [1:0] {
        WIdle,
        WData,
        WResp
    } wr_state_t;

    // RIssue is the cycle in which the first SRAM read of a burst is presented.
    typedef enum logic [1:0] {
        RIdle,
        RIssue,
        RData
    } rd_state_t;

endpackage

// File: rtl/axi_sram_burst_addr.sv
// Combinational AXI next-beat address calculator.
// Ports:
//   addr      in  current beat address
//   len       in  AxLEN (beats - 1)
//   size      in  AxSIZE (bytes per beat = 1 << size)
//   burst     in  burst type
//   next_addr out address of the following beat
// Reserved burst encoding and WRAP with an illegal length behave as INCR.
module axi_sram_burst_addr
    import axi_sram_pkg::*;
#(
    parameter int unsigned ADDR_W = AXI_ADDR_W
) (
    input  logic [ADDR_W-1:0]     addr,
    input  logic [AXI_LEN_W-1:0]  len,
    input  logic [AXI_SIZE_W-1:0] size,
    input  burst_t                burst,
    output logic [ADDR_W-1:0]     next_addr
);

    logic [ADDR_W-1:0] incr;
    logic [ADDR_W-1:0] seq_addr;
    logic [ADDR_W-1:0] wrap_mask;
    logic              wrap_ok;

    always_comb begin
        incr      = ADDR_W'(1) << size;
        seq_addr  = addr + incr;
        // wrap boundary is (len+1) << size; mask selects the offset inside it
        wrap_mask = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        case (burst)
            BurstFixed: next_addr = addr;
            BurstWrap: begin
                if (wrap_ok) begin
                    next_addr = (addr & ~wrap_mask) | (seq_addr & wrap_mask);
                end else begin
                    next_addr = seq_addr;
                end
            end
            default: next_addr = seq_addr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 responder backed by a 32-bit word SRAM (1R1W, registered read port).
// One outstanding transaction per direction, full-throughput W and R beats.
// Ports:
//   aclk, areset              clock, asynchronous active-high reset
//   s_aw*/s_awready           write address channel
//   s_w*/s_wready             write data channel (wlast ignored, AWLEN governs)
//   s_b*/s_bready             write response channel
//   s_ar*/s_arready           read address channel
//   s_r*/s_rready             read data channel
// Build option: define AXI_SRAM_SLVERR_EN to answer beats outside the
// BASE window with SLVERR (writes dropped, read data 0). Without it the
// address aliases modulo the SRAM size.
module axi_sram_slave
    import axi_sram_pkg::*;
#(
    parameter int unsigned       ID_W      = 6,
    parameter int unsigned       ADDR_W    = AXI_ADDR_W,
    parameter int unsigned       WORDS_LOG = 14,
    parameter logic [ADDR_W-1:0] BASE      = '0
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [ID_W-1:0]       s_awid,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic [AXI_LEN_W-1:0]  s_awlen,
    input  logic [AXI_SIZE_W-1:0] s_awsize,
    input  logic [1:0]            s_awburst,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [AXI_DATA_W-1:0] s_wdata,
    input  logic [AXI_STRB_W-1:0] s_wstrb,
    input  logic                  s_wlast,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [ID_W-1:0]       s_bid,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ID_W-1:0]       s_arid,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic [AXI_LEN_W-1:0]  s_arlen,
    input  logic [AXI_SIZE_W-1:0] s_arsize,
    input  logic [1:0]            s_arburst,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [ID_W-1:0]       s_rid,
    output logic [AXI_DATA_W-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rlast,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int unsigned DEPTH = 1 << WORDS_LOG;

    logic [AXI_DATA_W-1:0] mem [DEPTH];

    wr_state_t             w_state_q, w_state_d;
    logic [ID_W-1:0]       w_id_q, w_id_d;
    logic [ADDR_W-1:0]     w_addr_q, w_addr_d, w_next;
    logic [AXI_LEN_W-1:0]  w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [AXI_SIZE_W-1:0] w_size_q, w_size_d;
    burst_t                w_burst_q, w_burst_d;
    logic                  w_err_q, w_err_d;

    rd_state_t             r_state_q, r_state_d;
    logic [ID_W-1:0]       r_id_q, r_id_d;
    logic [ADDR_W-1:0]     r_addr_q, r_addr_d, r_next;
    logic [AXI_LEN_W-1:0]  r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [AXI_SIZE_W-1:0] r_size_q, r_size_d;
    burst_t                r_burst_q, r_burst_d;
    logic [1:0]            rresp_q;
    logic [AXI_DATA_W-1:0] rdata_q;

    logic                  mem_we, rd_en;
    logic [ADDR_W-1:0]     rd_addr, w_off, r_off;
    logic                  w_oob, r_oob, w_err, r_err;
    logic                  unused_bits;

    axi_sram_burst_addr #(.ADDR_W(ADDR_W)) u_w_addr (
        .addr      (w_addr_q),
        .len       (w_len_q),
        .size      (w_size_q),
        .burst     (w_burst_q),
        .next_addr (w_next)
    );

    axi_sram_burst_addr #(.ADDR_W(ADDR_W)) u_r_addr (
        .addr      (r_addr_q),
        .len       (r_len_q),
        .size      (r_size_q),
        .burst     (r_burst_q),
        .next_addr (r_next)
    );

    assign w_off = w_addr_q - BASE;
    assign r_off = rd_addr - BASE;

`ifdef AXI_SRAM_SLVERR_EN
    // Offsets below BASE wrap to huge values and fall outside the window too.
    assign w_oob = (w_off >> (WORDS_LOG + 2)) != '0;
    assign r_oob = (r_off >> (WORDS_LOG + 2)) != '0;
`else
    assign w_oob = 1'b0;
    assign r_oob = 1'b0;
`endif

    assign w_err = (w_size_q > 3'd2) || w_oob;
    assign r_err = (r_size_q > 3'd2) || r_oob;

    assign unused_bits = ^{s_wlast, w_off[1:0], w_off[ADDR_W-1:WORDS_LOG+2],
                           r_off[1:0], r_off[ADDR_W-1:WORDS_LOG+2]};

    // Write channel
    always_comb begin
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_size_d  = w_size_q;
        w_burst_d = w_burst_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        s_awready = 1'b0;
        s_wready  = 1'b0;
        s_bvalid  = 1'b0;
        mem_we    = 1'b0;
        case (w_state_q)
            WIdle: begin
                s_awready = ~areset;
                if (s_awvalid) begin
                    w_id_d    = s_awid;
                    w_addr_d  = s_awaddr;
                    w_len_d   = s_awlen;
                    w_size_d  = s_awsize;
                    w_burst_d = burst_t'(s_awburst);
                    w_cnt_d   = '0;
                    w_err_d   = 1'b0;
                    w_state_d = WData;
                end
            end
            WData: begin
                s_wready = 1'b1;
                if (s_wvalid) begin
                    mem_we   = ~w_err;
                    w_err_d  = w_err_q | w_err;
                    w_addr_d = w_next;
                    w_cnt_d  = w_cnt_q + 8'd1;
                    if (w_cnt_q == w_len_q) begin
                        w_state_d = WResp;
                    end
                end
            end
            WResp: begin
                s_bvalid = 1'b1;
                if (s_bready) begin
                    w_state_d = WIdle;
                end
            end
            default: w_state_d = WIdle;
        endcase
    end

    assign s_bid   = w_id_q;
    assign s_bresp = w_err_q ? RespSlverr : RespOkay;

    // Read channel
    always_comb begin
        r_state_d = r_state_q;
        r_id_d    = r_id_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_size_d  = r_size_q;
        r_burst_d = r_burst_q;
        r_cnt_d   = r_cnt_q;
        s_arready = 1'b0;
        s_rvalid  = 1'b0;
        rd_en     = 1'b0;
        rd_addr   = r_addr_q;
        case (r_state_q)
            RIdle: begin
                s_arready = ~areset;
                if (s_arvalid) begin
                    r_id_d    = s_arid;
                    r_addr_d  = s_araddr;
                    r_len_d   = s_arlen;
                    r_size_d  = s_arsize;
                    r_burst_d = burst_t'(s_arburst);
                    r_cnt_d   = '0;
                    r_state_d = RIssue;
                end
            end
            RIssue: begin
                rd_en     = 1'b1;
                r_state_d = RData;
            end
            RData: begin
                s_rvalid = 1'b1;
                if (s_rready) begin
                    if (s_rlast) begin
                        r_state_d = RIdle;
                    end else begin
                        // fetch the next beat now so it is valid right after this one
                        rd_en    = 1'b1;
                        rd_addr  = r_next;
                        r_addr_d = r_next;
                        r_cnt_d  = r_cnt_q + 8'd1;
                    end
                end
            end
            default: r_state_d = RIdle;
        endcase
    end

    assign s_rlast = (r_state_q == RData) && (r_cnt_q == r_len_q);
    assign s_rid   = r_id_q;
    assign s_rdata = rdata_q;
    assign s_rresp = rresp_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            w_state_q <= WIdle;
            w_id_q    <= '0;
            w_addr_q  <= '0;
            w_len_q   <= '0;
            w_size_q  <= '0;
            w_burst_q <= BurstIncr;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
            r_state_q <= RIdle;
            r_id_q    <= '0;
            r_addr_q  <= '0;
            r_len_q   <= '0;
            r_size_q  <= '0;
            r_burst_q <= BurstIncr;
            r_cnt_q   <= '0;
            rresp_q   <= RespOkay;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_size_q  <= w_size_d;
            w_burst_q <= w_burst_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_size_q  <= r_size_d;
            r_burst_q <= r_burst_d;
            r_cnt_q   <= r_cnt_d;
            if (rd_en) begin
                rresp_q <= r_err ? RespSlverr : RespOkay;
            end
        end
    end

    // SRAM: contents survive reset; read samples pre-write data (read-first).
    always_ff @(posedge aclk) begin
        if (mem_we) begin
            for (int b = 0; b < AXI_STRB_W; b++) begin
                if (s_wstrb[b]) begin
                    mem[w_off[WORDS_LOG+1:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                end
            end
        end
        if (rd_en) begin
            rdata_q <= r_oob ? '0 : mem[r_off[WORDS_LOG+1:2]];
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
module tb_axi_sram_slave;

    logic        aclk = 1'b0;
    logic        areset;
    logic [5:0]  s_awid, s_arid, s_bid, s_rid;
    logic [31:0] s_awaddr, s_araddr, s_wdata, s_rdata;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    logic [1:0]  s_awburst, s_arburst, s_bresp, s_rresp;
    logic [3:0]  s_wstrb;
    logic        s_awvalid, s_awready, s_wlast, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [5:0]  id;
    } rexp_t;

    typedef struct {
        logic [5:0] id;
        logic [1:0] resp;
    } bexp_t;

    rexp_t       r_sb[$];
    bexp_t       b_sb[$];
    logic [31:0] model [int unsigned];

    always #5 aclk = ~aclk;

    axi_sram_slave dut (
        .aclk      (aclk),
        .areset    (areset),
        .s_awid    (s_awid),
        .s_awaddr  (s_awaddr),
        .s_awlen   (s_awlen),
        .s_awsize  (s_awsize),
        .s_awburst (s_awburst),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wlast   (s_wlast),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bid     (s_bid),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_arid    (s_arid),
        .s_araddr  (s_araddr),
        .s_arlen   (s_arlen),
        .s_arsize  (s_arsize),
        .s_arburst (s_arburst),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rid     (s_rid),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rlast   (s_rlast),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of beat i, computed directly from the start address (4-byte beats).
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                              input logic [1:0] burst, input int i);
        int unsigned bnd;
        if (burst == 2'b00) return start;
        if (burst == 2'b10 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            bnd = 32'(len + 1) * 4;
            return (start / bnd) * bnd + ((start % bnd) + 32'(i) * 4) % bnd;
        end
        return start + 32'(i) * 4;
    endfunction

    function automatic int unsigned widx(input logic [31:0] a);
        return (a >> 2) % 16384;
    endfunction

    task automatic write_burst(input logic [5:0] id, input logic [31:0] addr, input int len,
                               input logic [1:0] burst, input logic [31:0] seed,
                               input logic [3:0] strb, input bit stall);
        int          n;
        logic [31:0] a, d, w;
        bexp_t       be, bg;
        s_awid = id; s_awaddr = addr; s_awlen = 8'(len); s_awsize = 3'd2;
        s_awburst = burst; s_awvalid = 1'b1;
        n = 0;
        while (!s_awready && n < 50) begin @(negedge aclk); n++; end
        check("aw_wait", 32'(n < 50), 32'd1);
        @(negedge aclk);
        s_awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            d = seed + 32'(i) * 32'h01010101;
            s_wdata = d; s_wstrb = strb; s_wlast = (i == len); s_wvalid = 1'b1;
            n = 0;
            while (!s_wready && n < 50) begin @(negedge aclk); n++; end
            a = beat_addr(addr, len, burst, i);
            w = model.exists(widx(a)) ? model[widx(a)] : 32'h0;
            for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = d[8*b +: 8];
            model[widx(a)] = w;
            @(negedge aclk);
        end
        s_wvalid = 1'b0; s_wlast = 1'b0;
        be.id = id; be.resp = 2'b00;
        b_sb.push_back(be);
        n = 0;
        while (n < 200) begin
            s_bready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_bvalid && s_bready) break;
            @(negedge aclk); n++;
        end
        check("b_wait", 32'(n < 200), 32'd1);
        bg = b_sb.pop_front();
        check("bid", 32'(s_bid), 32'(bg.id));
        check("bresp", 32'(s_bresp), 32'(bg.resp));
        @(negedge aclk);
        s_bready = 1'b0;
        check("b_done", 32'(s_bvalid), 32'd0);
    endtask

    task automatic read_burst(input logic [5:0] id, input logic [31:0] addr, input int len,
                              input logic [1:0] burst, input bit stall, input bit timing);
        int          n, cyc, got, first;
        logic [31:0] a, held;
        bit          held_v;
        rexp_t       e;
        for (int i = 0; i <= len; i++) begin
            a = beat_addr(addr, len, burst, i);
            e.id = id; e.last = (i == len);
`ifdef AXI_SRAM_SLVERR_EN
            if (a >= 32'h0001_0000) begin
                e.data = 32'h0; e.resp = 2'b10;
            end else begin
                e.data = model[widx(a)]; e.resp = 2'b00;
            end
`else
            e.data = model[widx(a)]; e.resp = 2'b00;
`endif
            r_sb.push_back(e);
        end
        s_arid = id; s_araddr = addr; s_arlen = 8'(len); s_arsize = 3'd2;
        s_arburst = burst; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin @(negedge aclk); n++; end
        check("ar_wait", 32'(n < 50), 32'd1);
        @(negedge aclk);
        s_arvalid = 1'b0;
        if (timing) begin
            check("rvalid_t1", 32'(s_rvalid), 32'd0);
            @(negedge aclk);
            check("rvalid_t2", 32'(s_rvalid), 32'd1);
        end
        got = 0; cyc = 0; first = -1; held_v = 1'b0; held = '0;
        while (got <= len && cyc < 500) begin
            if (held_v) begin
                check("r_stall_valid", 32'(s_rvalid), 32'd1);
                check("r_stall_data", s_rdata, held);
            end
            s_rready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (s_rvalid) begin
                if (first < 0) first = cyc;
                if (s_rready) begin
                    e = r_sb.pop_front();
                    check("rdata", s_rdata, e.data);
                    check("rresp", 32'(s_rresp), 32'(e.resp));
                    check("rlast", 32'(s_rlast), 32'(e.last));
                    check("rid", 32'(s_rid), 32'(e.id));
                    got++;
                    held_v = 1'b0;
                end else begin
                    held = s_rdata; held_v = 1'b1;
                end
            end
            @(negedge aclk); cyc++;
        end
        s_rready = 1'b0;
        check("r_beats", 32'(got), 32'(len + 1));
        if (!stall) check("r_nogap", 32'(cyc - first), 32'(len + 1));
        check("r_done", 32'(s_rvalid), 32'd0);
        r_sb.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, got;
        areset = 1'b1;
        s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = '0; s_awburst = '0;
        s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b0; s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0;
        s_arburst = '0; s_arvalid = 1'b0; s_rready = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_awready", 32'(s_awready), 32'd0);
        check("rst_arready", 32'(s_arready), 32'd0);
        check("rst_wready", 32'(s_wready), 32'd0);
        check("rst_bvalid", 32'(s_bvalid), 32'd0);
        check("rst_rvalid", 32'(s_rvalid), 32'd0);
        check("rst_bresp", 32'(s_bresp), 32'd0);
        check("rst_rresp", 32'(s_rresp), 32'd0);
        check("rst_rlast", 32'(s_rlast), 32'd0);
        areset = 1'b0;
        @(negedge aclk);
        check("idle_awready", 32'(s_awready), 32'd1);
        check("idle_arready", 32'(s_arready), 32'd1);
        check("idle_wready", 32'(s_wready), 32'd0);

        // single beat write/read, then a partial-strobe overwrite
        write_burst(6'h15, 32'h1000, 0, 2'b01, 32'hDEADBEEF, 4'hF, 1'b0);
        read_burst(6'h15, 32'h1000, 0, 2'b01, 1'b0, 1'b1);
        write_burst(6'h07, 32'h1000, 0, 2'b01, 32'hAA55AA55, 4'b0100, 1'b0);
        read_burst(6'h08, 32'h1000, 0, 2'b01, 1'b0, 1'b0);

        // INCR len 7, back-to-back read
        write_burst(6'h01, 32'h2000, 7, 2'b01, 32'h11111111, 4'hF, 1'b0);
        read_burst(6'h02, 32'h2000, 7, 2'b01, 1'b0, 1'b1);

        // WRAP len 3 from 0x3008, verified through linear and wrapping reads
        write_burst(6'h03, 32'h3000, 3, 2'b01, 32'h0, 4'hF, 1'b0);
        write_burst(6'h04, 32'h3008, 3, 2'b10, 32'hA0A0A000, 4'hF, 1'b0);
        read_burst(6'h05, 32'h3000, 3, 2'b01, 1'b0, 1'b0);
        read_burst(6'h06, 32'h3008, 3, 2'b10, 1'b0, 1'b0);
        // FIXED read returns the same word every beat
        read_burst(6'h09, 32'h2004, 3, 2'b00, 1'b0, 1'b0);

        // 16-beat transfers with random back-pressure
        write_burst(6'h2A, 32'h4000, 15, 2'b01, 32'h5A000001, 4'hF, 1'b1);
        read_burst(6'h2B, 32'h4000, 15, 2'b01, 1'b1, 1'b0);

        // one past the window: SLVERR or alias of word 0 depending on build
        write_burst(6'h0A, 32'h0, 0, 2'b01, 32'h12345678, 4'hF, 1'b0);
        read_burst(6'h0B, 32'h0001_0000, 0, 2'b01, 1'b0, 1'b0);

        // reset while beat 3 of an 8-beat read is on the bus
        s_arid = 6'h33; s_araddr = 32'h2000; s_arlen = 8'd7; s_arsize = 3'd2;
        s_arburst = 2'b01; s_arvalid = 1'b1;
        n = 0;
        while (!s_arready && n < 50) begin @(negedge aclk); n++; end
        @(negedge aclk);
        s_arvalid = 1'b0;
        s_rready = 1'b1;
        got = 0; n = 0;
        while (got < 3 && n < 50) begin
            if (s_rvalid) begin
                check("abort_rdata", s_rdata, model[widx(32'h2000 + 32'(got) * 4)]);
                got++;
            end
            @(negedge aclk); n++;
        end
        check("abort_beats", 32'(got), 32'd3);
        check("abort_pre_rvalid", 32'(s_rvalid), 32'd1);
        s_rready = 1'b0;
        areset = 1'b1;
        #1;
        check("abort_rvalid", 32'(s_rvalid), 32'd0);
        check("abort_arready_in_rst", 32'(s_arready), 32'd0);
        @(negedge aclk);
        check("abort_rvalid_2", 32'(s_rvalid), 32'd0);
        areset = 1'b0;
        #1;
        check("abort_arready", 32'(s_arready), 32'd1);
        check("abort_rlast", 32'(s_rlast), 32'd0);
        @(negedge aclk);
        read_burst(6'h34, 32'h2000, 7, 2'b01, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
